// File: rtl/upscale2x_stream.sv
// Streaming 2x image upscaler. Buffers one input row at a time into a pair of
// ping-pong line buffers, then emits two output rows (TOP = 2y, BOT = 2y+1)
// from the current and previous rows, either by pixel replication (nearest)
// or by rounded bilinear interpolation with edge clamping.
//
// state | meaning
// ------+--------------------------------------------------------------
// LOAD  | accepting input row y into the current line buffer
// TOP   | emitting output row 2y (interpolated between rows y-1 and y)
// BOT   | emitting output row 2y+1 (row y only)
module upscale2x_stream #(
  parameter int WIDTH    = 384,
  parameter int HEIGHT   = 256,
  parameter int CHANNELS = 3,
  parameter int DW       = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CHANNELS*DW-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CHANNELS*DW-1:0] out_data,
  output logic                   out_last,
  output logic                   out_frame_end,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = XW + 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int PW = CHANNELS * DW;

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [CW-1:0] C_LAST = CW'(2 * WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_TOP  = 2'd1,
    S_BOT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] col_q, col_d;
  logic          swap_q, swap_d;
  logic          mode_q, mode_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          out_valid_q, out_valid_d;
  logic [PW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          out_fe_q, out_fe_d;

  // Line buffers are intentionally not reset; every location is written before it is read.
  logic [PW-1:0] lbuf0_q [WIDTH];
  logic [PW-1:0] lbuf1_q [WIDTH];
  logic          lbuf_we;

  logic [XW-1:0] xc, xl;
  logic [PW-1:0] cur_p, cur_l, prv_p, prv_l, pix;
  logic          first_row, is_bot, odd_col;
  logic          out_xfer, out_load;

  assign out_xfer = out_valid_q & out_ready;
  assign out_load = (state_q != S_LOAD) && (!out_valid_q || out_ready);

  // swap_q selects which buffer is "current"; the other holds the previous row.
  assign xc        = col_q[CW-1:1];
  assign xl        = (xc == '0) ? xc : xc - XW'(1);
  assign cur_p     = swap_q ? lbuf1_q[xc] : lbuf0_q[xc];
  assign cur_l     = swap_q ? lbuf1_q[xl] : lbuf0_q[xl];
  assign prv_p     = swap_q ? lbuf0_q[xc] : lbuf1_q[xc];
  assign prv_l     = swap_q ? lbuf0_q[xl] : lbuf1_q[xl];
  assign first_row = (y_q == '0);
  assign is_bot    = (state_q == S_BOT);
  assign odd_col   = col_q[0];

  // Write the accepted input pixel into the current row buffer.
  always_ff @(posedge clock) begin
    if (lbuf_we) begin
      if (swap_q) lbuf1_q[x_q] <= in_data;
      else        lbuf0_q[x_q] <= in_data;
    end
  end

  // Per-channel output sample for the current output column; channels never interact.
  always_comb begin : pix_calc
    logic [DW-1:0] p, l, u, ul, r;
    logic [DW+1:0] s4;
    logic [DW:0]   s2u, s2l;
    pix = '0;
    p   = '0;
    l   = '0;
    u   = '0;
    ul  = '0;
    r   = '0;
    s4  = '0;
    s2u = '0;
    s2l = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      p   = cur_p[ch*DW +: DW];
      l   = cur_l[ch*DW +: DW];
      u   = first_row ? p : prv_p[ch*DW +: DW];
      ul  = first_row ? l : prv_l[ch*DW +: DW];
      s4  = {2'b00, p} + {2'b00, l} + {2'b00, u} + {2'b00, ul} + (DW+2)'(2);
      s2u = {1'b0, p} + {1'b0, u} + (DW+1)'(1);
      s2l = {1'b0, p} + {1'b0, l} + (DW+1)'(1);
      if (!mode_q)                r = p;
      else if (!is_bot && !odd_col) r = DW'(s4 >> 2);
      else if (!is_bot)           r = DW'(s2u >> 1);
      else if (!odd_col)          r = DW'(s2l >> 1);
      else                        r = p;
      pix[ch*DW +: DW] = r;
    end
  end

  // Sequencing: row load, two output rows, row advance and frame completion.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    col_d        = col_q;
    swap_d       = swap_q;
    mode_d       = mode_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_fe_d     = out_fe_q;
    in_ready     = (state_q == S_LOAD);
    lbuf_we      = 1'b0;

    if (out_xfer) out_valid_d = 1'b0;

    // Final pixel of the frame leaves; keep busy if the next frame has already started.
    if (out_xfer && out_fe_q) begin
      frame_done_d = 1'b1;
      if (state_q == S_LOAD && x_q == '0 && y_q == '0) busy_d = 1'b0;
    end

    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          lbuf_we = 1'b1;
          if (x_q == '0 && y_q == '0) begin
            mode_d = mode;
            busy_d = 1'b1;
          end
          if (x_q == X_LAST) begin
            x_d     = '0;
            col_d   = '0;
            state_d = S_TOP;
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      S_TOP, S_BOT: begin
        if (out_load) begin
          out_valid_d = 1'b1;
          out_data_d  = pix;
          out_last_d  = (col_q == C_LAST);
          out_fe_d    = is_bot && (col_q == C_LAST) && (y_q == Y_LAST);
          if (col_q == C_LAST) begin
            col_d = '0;
            if (state_q == S_TOP) begin
              state_d = S_BOT;
            end else begin
              state_d = S_LOAD;
              if (y_q == Y_LAST) begin
                y_d = '0;
              end else begin
                y_d    = y_q + YW'(1);
                swap_d = ~swap_q;
              end
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State and output registers with synchronous reset; pending output is dropped on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_LOAD;
      x_q          <= '0;
      y_q          <= '0;
      col_q        <= '0;
      swap_q       <= 1'b0;
      mode_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_fe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      col_q        <= col_d;
      swap_q       <= swap_d;
      mode_q       <= mode_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_fe_q     <= out_fe_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_last      = out_last_q;
  assign out_frame_end = out_fe_q;
  assign frame_done    = frame_done_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_upscale2x_stream.sv
// Bench for upscale2x_stream on a 4x2 frame with three 8-bit channels.
module tb_upscale2x_stream;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int CH   = 3;
  localparam int DW   = 8;
  localparam int PW   = CH * DW;
  localparam int NIN  = W * H;
  localparam int NOUT = 4 * NIN;

  localparam int ROW_A   [NIN]  = '{10, 20, 30, 40, 50, 60, 70, 80};
  localparam int BIL_EX  [NOUT] = '{10, 10, 15, 20, 25, 30, 35, 40,
                                    10, 10, 15, 20, 25, 30, 35, 40,
                                    30, 30, 35, 40, 45, 50, 55, 60,
                                    50, 50, 55, 60, 65, 70, 75, 80};
  localparam int NEAR_EX [NOUT] = '{10, 10, 20, 20, 30, 30, 40, 40,
                                    10, 10, 20, 20, 30, 30, 40, 40,
                                    50, 50, 60, 60, 70, 70, 80, 80,
                                    50, 50, 60, 60, 70, 70, 80, 80};

  typedef struct packed {
    logic                      m;
    logic [1:0]                rdy;
    logic [NIN-1:0][DW-1:0]    px;
    logic [NOUT-1:0][DW-1:0]   ex;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset, mode, in_valid, in_ready, out_valid, out_ready;
  logic          out_last, out_frame_end, frame_done, busy;
  logic [PW-1:0] in_data, out_data;

  always #5 clock = ~clock;

  upscale2x_stream #(.WIDTH(W), .HEIGHT(H), .CHANNELS(CH), .DW(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .mode         (mode),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_frame_end(out_frame_end),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] stim_px  [NIN];
  logic [PW-1:0] exp_data [NOUT];
  logic          exp_last [NOUT];
  logic          exp_fe   [NOUT];
  logic [PW-1:0] got_data [NOUT];
  logic          got_last [NOUT];
  logic          got_fe   [NOUT];
  int            got_cnt, n_in, fd_cnt;
  vec_t          vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: upscale the whole image held in stim_px with plain arithmetic.
  task automatic build_expected(input bit m);
    for (int oy = 0; oy < 2*H; oy++) begin
      for (int ox = 0; ox < 2*W; ox++) begin
        int k, y, x, ym, xm, p, l, u, ul, r;
        bit bot, odd;
        k   = oy * 2*W + ox;
        y   = oy / 2;
        x   = ox / 2;
        ym  = (y > 0) ? y - 1 : 0;
        xm  = (x > 0) ? x - 1 : 0;
        bot = (oy % 2) == 1;
        odd = (ox % 2) == 1;
        for (int c = 0; c < CH; c++) begin
          p  = int'(stim_px[y*W + x][c*DW +: DW]);
          l  = int'(stim_px[y*W + xm][c*DW +: DW]);
          u  = int'(stim_px[ym*W + x][c*DW +: DW]);
          ul = int'(stim_px[ym*W + xm][c*DW +: DW]);
          if (!m)               r = p;
          else if (!bot && !odd) r = (p + l + u + ul + 2) / 4;
          else if (!bot)        r = (p + u + 1) / 2;
          else if (!odd)        r = (p + l + 1) / 2;
          else                  r = p;
          exp_data[k][c*DW +: DW] = DW'(r);
        end
        exp_last[k] = (ox == 2*W - 1);
        exp_fe[k]   = (k == NOUT - 1);
      end
    end
  endtask

  task automatic drive_inputs(input bit m, input bit gaps, input bit flip, input int n);
    for (int i = 0; i < n; i++) begin
      int t;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data  = PW'($urandom);
          @(negedge clock);
        end
      end
      in_valid = 1'b1;
      in_data  = stim_px[i];
      if (i == 0) mode = m;
      else if (flip) mode = ~m;
      t = 0;
      while (!in_ready && t < 400) begin
        @(negedge clock);
        t++;
      end
      if (!in_ready) begin
        check("in_ready_wait", in_ready, 1);
        break;
      end
      @(negedge clock);
      n_in++;
    end
    in_valid = 1'b0;
    in_data  = PW'($urandom);
  endtask

  task automatic collect(input int rdy_pat, input int n);
    int             cyc;
    bit             stalled, busy_seen;
    logic [PW+1:0]  held;
    cyc = 0;
    stalled = 0;
    busy_seen = 0;
    held = '0;
    while (got_cnt < n && cyc < 2000) begin
      @(negedge clock);
      cyc++;
      if (frame_done) fd_cnt++;
      if (stalled)
        check("stall_hold", {out_valid, out_data, out_last, out_frame_end}, {1'b1, held});
      case (rdy_pat)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 1) || (cyc % 4 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (n_in > 0 && n_in % W == 0 && got_cnt < (n_in / W) * 4 * W - 2)
        check("in_ready_low", in_ready, 0);
      if (out_valid && out_ready) begin
        got_data[got_cnt] = out_data;
        got_last[got_cnt] = out_last;
        got_fe[got_cnt]   = out_frame_end;
        got_cnt++;
        stalled = 0;
      end else begin
        stalled = out_valid;
        held    = {out_data, out_last, out_frame_end};
      end
      if (got_cnt == n / 2 && !busy_seen) begin
        busy_seen = 1;
        check("busy_mid", busy, 1);
      end
    end
    check("out_count", got_cnt, n);
    repeat (3) begin
      @(negedge clock);
      if (frame_done) fd_cnt++;
    end
  endtask

  task automatic run_frame(input bit m, input int rdy, input bit gaps, input bit flip,
                           input int nin, input int nout);
    got_cnt = 0;
    n_in    = 0;
    fd_cnt  = 0;
    fork
      drive_inputs(m, gaps, flip, nin);
      collect(rdy, nout);
    join
  endtask

  task automatic compare(input string tag, input int n, input int exp_fd);
    for (int k = 0; k < n; k++)
      check($sformatf("%s px%0d", tag, k),
            {got_data[k], got_last[k], got_fe[k]},
            {exp_data[k], exp_last[k], exp_fe[k]});
    check({tag, " frame_done"}, fd_cnt, exp_fd);
    check({tag, " busy_end"}, busy, (exp_fd != 0) ? 0 : 1);
  endtask

  task automatic load_vec(input int v);
    for (int i = 0; i < NIN; i++) stim_px[i] = {CH{vecs[v].px[i]}};
    for (int k = 0; k < NOUT; k++) begin
      exp_data[k] = {CH{vecs[v].ex[k]}};
      exp_last[k] = (k % (2*W) == 2*W - 1);
      exp_fe[k]   = (k == NOUT - 1);
    end
  endtask

  initial begin
    reset     = 1'b1;
    mode      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    vecs[0].m = 1'b1; vecs[0].rdy = 2'd0;
    vecs[1].m = 1'b0; vecs[1].rdy = 2'd0;
    vecs[2].m = 1'b1; vecs[2].rdy = 2'd0;
    vecs[3].m = 1'b1; vecs[3].rdy = 2'd0;
    vecs[4].m = 1'b1; vecs[4].rdy = 2'd1;
    for (int i = 0; i < NIN; i++) begin
      vecs[0].px[i] = DW'(ROW_A[i]);
      vecs[1].px[i] = DW'(ROW_A[i]);
      vecs[2].px[i] = 8'd255;
      vecs[3].px[i] = 8'd0;
      vecs[4].px[i] = DW'(ROW_A[i]);
    end
    for (int k = 0; k < NOUT; k++) begin
      vecs[0].ex[k] = DW'(BIL_EX[k]);
      vecs[1].ex[k] = DW'(NEAR_EX[k]);
      vecs[2].ex[k] = 8'd255;
      vecs[3].ex[k] = 8'd0;
      vecs[4].ex[k] = DW'(BIL_EX[k]);
    end

    repeat (3) @(negedge clock);
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst out_last", out_last, 0);
    check("rst out_frame_end", out_frame_end, 0);
    check("rst frame_done", frame_done, 0);
    check("rst busy", busy, 0);
    reset = 1'b0;
    @(negedge clock);

    for (int v = 0; v < 5; v++) begin
      load_vec(v);
      run_frame(vecs[v].m, int'(vecs[v].rdy), 0, 0, NIN, NOUT);
      compare($sformatf("vec%0d", v), NOUT, 1);
    end

    // First-output latency, held output under stall, and reset dropping it.
    load_vec(0);
    out_ready = 1'b0;
    n_in = 0;
    drive_inputs(1, 0, 0, W);
    check("lat out_valid_early", out_valid, 0);
    @(negedge clock);
    check("lat out_valid", out_valid, 1);
    check("lat out_data", out_data, {CH{8'd10}});
    check("lat in_ready", in_ready, 0);
    repeat (2) @(negedge clock);
    check("hold out_valid", out_valid, 1);
    check("hold out_data", out_data, {CH{8'd10}});
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("drop out_valid", out_valid, 0);
    check("drop in_ready", in_ready, 1);
    check("drop busy", busy, 0);
    run_frame(1, 0, 0, 0, NIN, NOUT);
    compare("after_drop", NOUT, 1);

    // Reset after six inputs, then a fresh frame.
    run_frame(1, 0, 0, 0, 6, 16);
    compare("pre_reset", 16, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst out_valid", out_valid, 0);
    check("midrst in_ready", in_ready, 1);
    check("midrst busy", busy, 0);
    run_frame(1, 0, 0, 0, NIN, NOUT);
    compare("post_reset", NOUT, 1);

    // Constant three-channel pixel with the mode pin flipped mid-frame.
    for (int i = 0; i < NIN; i++) stim_px[i] = {8'd200, 8'd100, 8'd0};
    for (int k = 0; k < NOUT; k++) begin
      exp_data[k] = {8'd200, 8'd100, 8'd0};
      exp_last[k] = (k % (2*W) == 2*W - 1);
      exp_fe[k]   = (k == NOUT - 1);
    end
    run_frame(1, 0, 0, 1, NIN, NOUT);
    compare("rgb_const", NOUT, 1);

    // Random images, random mode, input gaps, random back-pressure, mode flips.
    for (int f = 0; f < 8; f++) begin
      bit m, flip;
      for (int i = 0; i < NIN; i++) stim_px[i] = PW'($urandom);
      m    = 1'($urandom_range(0, 1));
      flip = 1'($urandom_range(0, 1));
      build_expected(m);
      run_frame(m, 2, 1, flip, NIN, NOUT);
      compare($sformatf("rand%0d", f), NOUT, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
